// File: rtl/mem_write_fifo.sv
// mem_write_fifo: buffers controller write bursts as single pixel writes and drains them
// to an Avalon-MM write master, counting completed beats to flag frame boundaries.
module mem_write_fifo #(
  parameter int DEPTH        = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [31:0]                  write_address,
  input  logic [31:0]                  write_data,
  input  logic                         write_enable,
  output logic                         wait_request,
  output logic [31:0]                  avm_address,
  output logic [31:0]                  avm_writedata,
  output logic [3:0]                   avm_byteenable,
  output logic                         avm_write,
  input  logic                         avm_waitrequest,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         frame_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   beat_cnt;
  logic          armed;
  logic          push;
  logic          pop;
  logic          frame_end;
  assign wait_request   = level == LW'(DEPTH);
  assign push           = write_enable && !wait_request && armed;
  assign avm_write      = level != '0;
  assign pop            = avm_write && !avm_waitrequest;
  assign frame_end      = pop && beat_cnt == 32'(FRAME_PIXELS - 1);
  assign avm_byteenable = 4'hF;
  // Gating on avm_write keeps the bus fields at zero while empty, including after reset.
  assign avm_address    = avm_write ? addr_mem[rd_ptr] : '0;
  assign avm_writedata  = avm_write ? data_mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      armed      <= 1'b1;
      beat_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr     <= push ? wr_ptr + PW'(1) : wr_ptr;
      level      <= (push && !pop) ? level + LW'(1) : ((pop && !push) ? level - LW'(1) : level);
      armed      <= push ? 1'b0 : (!write_enable ? 1'b1 : armed);
      beat_cnt   <= frame_end ? '0 : (pop ? beat_cnt + 32'd1 : beat_cnt);
      frame_done <= frame_end;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= write_address;
      data_mem[wr_ptr] <= write_data;
    end
  end
endmodule

// File: tb/tb_mem_write_fifo.sv
// tb_mem_write_fifo: directed and randomized bursts checked against a queue-based model.
module tb_mem_write_fifo;
  localparam int DEPTH = 4;
  localparam int FP    = 3;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  logic        clk = 0;
  logic        n_rst;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        we;
  logic        wait_request;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic        awr;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic        frame_done;
  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  bit   m_armed = 1;
  int   total = 0;
  bit   fd_exp = 0;
  bit   rnd = 0;
  int   dut_beats = 0;
  int   dut_fd = 0;
  mem_write_fifo #(.DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .n_rst(n_rst), .write_address(wa), .write_data(wd), .write_enable(we),
    .wait_request(wait_request), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_write(avm_write), .avm_waitrequest(awr),
    .level(level), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_armed = 1;
    total = 0;
    fd_exp = 0;
  endtask
  // One clock cycle: compare DUT against the model, then advance the model across the edge.
  task automatic tick();
    bit pop;
    bit push;
    if (rnd) awr = 1'($urandom_range(0, 1));
    #1;
    chk("level", 32'(level), q.size());
    chk("wait_request", 32'(wait_request), 32'(q.size() == DEPTH));
    chk("avm_write", 32'(avm_write), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("avm_address", avm_address, q[0].a);
      chk("avm_writedata", avm_writedata, q[0].d);
    end else begin
      chk("avm_address_idle", avm_address, 0);
      chk("avm_writedata_idle", avm_writedata, 0);
    end
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    if (avm_write && !awr) dut_beats++;
    if (frame_done) dut_fd++;
    pop  = q.size() != 0 && !awr;
    push = we && q.size() < DEPTH && m_armed;
    fd_exp = 0;
    if (pop) begin
      void'(q.pop_front());
      total++;
      fd_exp = (total % FP) == 0;
    end
    if (push) q.push_back(ent_t'{wa, wd});
    m_armed = push ? 0 : (!we ? 1 : m_armed);
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bit got = 0;
    wa = a;
    wd = d;
    we = 1;
    while ((!got || n < 2) && n < 40) begin
      if (m_armed && q.size() < DEPTH) got = 1;
      tick();
      n++;
    end
    chk("burst_accept", 32'(got), 1);
    we = 0;
    tick();
    tick();
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);
    tick();
  endtask
  initial begin
    n_rst = 0;
    we = 0;
    wa = 0;
    wd = 0;
    awr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_avm_write", 32'(avm_write), 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_avm_writedata", avm_writedata, 0);
    chk("rst_wait_request", 32'(wait_request), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("byteenable", 32'(avm_byteenable), 32'hF);
    n_rst = 1;
    // Frame pulse: 7 beats with FRAME_PIXELS=3 give pulses after beats 3 and 6 only
    dut_fd = 0;
    for (int i = 0; i < 7; i++) burst(32'h2000 + 32'(i) * 4, $urandom);
    repeat (3) tick();
    chk("frame_pulses", dut_fd, 2);
    // Single write
    dut_beats = 0;
    burst(32'h100, 32'hDEADBEEF);
    drain();
    chk("single_beats", dut_beats, 1);
    chk("single_level", 32'(level), 0);
    // Fill and back-pressure
    dut_beats = 0;
    awr = 1;
    for (int i = 0; i < 4; i++) burst(32'h300 + 32'(i), 32'hA000 + 32'(i));
    chk("fill_level", 32'(level), DEPTH);
    chk("fill_wait_request", 32'(wait_request), 1);
    wa = 32'h3FF;
    wd = 32'hA0FF;
    we = 1;
    repeat (4) tick();
    chk("fill_held_off", 32'(level), DEPTH);
    awr = 0;
    repeat (3) tick();
    we = 0;
    drain();
    chk("fill_beats", dut_beats, 5);
    // Back-to-back drain
    awr = 1;
    for (int i = 0; i < DEPTH; i++) burst(32'h400 + 32'(i) * 4, $urandom);
    awr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("b2b_write", 32'(avm_write), 1);
      chk("b2b_level", 32'(level), DEPTH - i);
      tick();
    end
    chk("b2b_idle", 32'(avm_write), 0);
    // Random stall: model tracks head stability, order, loss and duplication
    dut_beats = 0;
    rnd = 1;
    for (int i = 0; i < 20; i++) begin
      burst($urandom, $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd = 0;
    awr = 0;
    drain();
    chk("rand_beats", dut_beats, 20);
    // Reset mid-operation with a request held across release
    awr = 1;
    for (int i = 0; i < 3; i++) burst(32'h500 + 32'(i), $urandom);
    chk("pre_rst_level", 32'(level), 3);
    wa = 32'h600;
    wd = 32'hC0FFEE01;
    we = 1;
    n_rst = 0;
    #1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_avm_write", 32'(avm_write), 0);
    chk("mid_rst_avm_address", avm_address, 0);
    chk("mid_rst_wait_request", 32'(wait_request), 0);
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1;
    awr = 0;
    dut_beats = 0;
    repeat (2) tick();
    we = 0;
    repeat (3) tick();
    chk("post_rst_beats", dut_beats, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
